arc4_prga_engine: RTL and testbench
===================================

ARC4_PRGA_ENGINE -- requirements
Module: arc4_prga_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the byte width of message, result and S memory data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the address width of all three memories.
REQ-003 SHALL have parameter MSG_LEN_MAX, default 255, the maximum number of payload bytes processed.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset; asynchronous assert, active-low.
REQ-006 SHALL have ports start (input, 1, request) and rdy (output, 1, request accepted when high).
REQ-007 SHALL have port finish, output, 1, high while the last run is complete.
REQ-008 SHALL have ports msg_addr (output, ADDR_WIDTH) and msg_q (input, DATA_WIDTH), the ciphertext ROM with 1-cycle synchronous read.
REQ-009 SHALL have ports result_addr (output, ADDR_WIDTH), result_data (output, DATA_WIDTH) and result_wren (output, 1), the plaintext RAM.
REQ-010 SHALL have ports s_addr (output, ADDR_WIDTH), s_data (output, DATA_WIDTH), s_wren (output, 1) and s_q (input, DATA_WIDTH), the S RAM with 1-cycle read; S is pre-loaded by the key schedule.
REQ-011 SHALL have port key_valid, output, 1, the plaintext check verdict.

Function
REQ-012 SHALL treat msg[0] as length L; the effective length Le SHALL be min(L, MSG_LEN_MAX).
REQ-013 SHALL write result[0]=Le, then for k=1..Le: i=i+1, j=j+S[i], swap S[i]/S[j], result[k]=msg[k] XOR S[S[i]+S[j]].
REQ-014 SHALL compute i, j and the pad index modulo 2^DATA_WIDTH; i and j SHALL be 0 at each accepted start.
REQ-015 SHALL use states IDLE, RD_LEN, WAIT_LEN, WR_LEN, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_OUT and DONE.
REQ-016 SHALL use exactly 3 cycles for the length phase and 9 cycles per payload byte; finish SHALL rise 3+9*Le cycles after the accepting edge.
REQ-017 SHALL hold rdy=1 only in IDLE and DONE and SHALL accept start only when rdy=1; start while busy SHALL be ignored.
REQ-018 SHALL hold finish from DONE entry until the next accepted start, at which point finish SHALL drop on the following edge.
REQ-019 SHALL for Le=0 write only result[0]=0, issue no s_wren and go to DONE.
REQ-020 SHALL assert each write strobe for exactly one cycle per write and SHALL perform no other writes.
REQ-021 SHALL perform the swap at i==j as two writes of the same value.

Reset
REQ-022 SHALL on rst_n=0 enter IDLE and set rdy=1, finish=0, all wren=0, all addr/data=0 and key_valid=1, including mid-run; S contents are not restored.

Configuration
REQ-023 SHALL, with ARC4_ASCII_CHECK_EN defined, clear key_valid and go straight to DONE on the first plaintext byte k>=1 outside 0x20..0x7E; that byte SHALL be neither written nor followed by further bytes.
REQ-024 SHALL, without ARC4_ASCII_CHECK_EN, tie key_valid to 1 and never abort.
REQ-025 SHALL set key_valid to 1 at each accepted start.

Structure
REQ-026 SHALL place the state enum and the constants ASCII_MIN=0x20 and ASCII_MAX=0x7E in package arc4_pkg.
REQ-027 SHALL be a single module with no sub-module; the range check SHALL be inline logic.

Verification
REQ-028 SHALL cover: S[n]=n, msg={01,41} -> result={01,43}, finish after 12 cycles, S unchanged.
REQ-029 SHALL cover: msg[0]=00 -> result[0]=00 only, no s_wren, finish after 3 cycles.
REQ-030 SHALL cover: with the macro, S identity, msg={02,02,41} -> key_valid=0, result[1] not written, finish asserted.
REQ-031 SHALL cover: MSG_LEN_MAX=32, msg[0]=C8 -> result[0]=20, exactly 33 result writes.
REQ-032 SHALL cover: rst_n pulsed low at cycle 20 of a run -> IDLE immediately, wren low, a new start with re-loaded S gives the correct result.
REQ-033 SHALL cover: start re-asserted mid-run -> ignored, output matches the known 32-byte vector.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 keystream/decrypt engine.
package arc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WAIT_LEN,
    WR_LEN,
    RD_SI,
    WAIT_SI,
    RD_SJ,
    WAIT_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WAIT_PAD,
    WR_OUT,
    DONE
  } arc4_state_e;

  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

endpackage

// File: rtl/arc4_prga_engine.sv
// ARC4 PRGA: decrypts a length-prefixed message using a pre-loaded S memory.
// Define ARC4_ASCII_CHECK_EN to abort on the first non-printable plaintext byte.
module arc4_prga_engine
  import arc4_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int MSG_LEN_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  rdy,
  output logic                  finish,
  output logic [ADDR_WIDTH-1:0] msg_addr,
  input  logic [DATA_WIDTH-1:0] msg_q,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  result_wren,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_wren,
  input  logic [DATA_WIDTH-1:0] s_q,
  output logic                  key_valid
);

  // Counter width must hold both a byte index and a length value.
  localparam int CW = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam logic [CW-1:0] LEN_MAX = CW'(MSG_LEN_MAX);

  arc4_state_e state_reg, state_next;

  logic [DATA_WIDTH-1:0] i_reg, j_reg, si_reg, sj_reg, out_reg;
  logic [CW-1:0]         k_reg, len_reg;
  logic [CW-1:0]         len_raw;
  logic [DATA_WIDTH-1:0] pad_idx;
  logic [DATA_WIDTH-1:0] plain;
  logic                  bad_byte;
  logic                  accept;

  assign len_raw = CW'(msg_q);
  assign pad_idx = si_reg + sj_reg;
  assign plain   = msg_q ^ s_q;
  assign accept  = start && (state_reg == IDLE || state_reg == DONE);

`ifdef ARC4_ASCII_CHECK_EN
  logic key_valid_reg;

  assign bad_byte  = (plain < DATA_WIDTH'(ASCII_MIN)) || (plain > DATA_WIDTH'(ASCII_MAX));
  assign key_valid = key_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_reg <= 1'b1;
    end else if (accept) begin
      key_valid_reg <= 1'b1;
    end else if (state_reg == WAIT_PAD && bad_byte) begin
      key_valid_reg <= 1'b0;
    end
  end
`else
  assign bad_byte  = 1'b0;
  assign key_valid = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rdy         = 1'b0;
    finish      = 1'b0;
    msg_addr    = '0;
    result_addr = '0;
    result_data = '0;
    result_wren = 1'b0;
    s_addr      = '0;
    s_data      = '0;
    s_wren      = 1'b0;
    case (state_reg)
      IDLE: begin
        rdy = 1'b1;
        if (start) state_next = RD_LEN;
      end
      RD_LEN:   state_next = WAIT_LEN;
      WAIT_LEN: state_next = WR_LEN;
      WR_LEN: begin
        result_data = DATA_WIDTH'(len_reg);
        result_wren = 1'b1;
        state_next  = (len_reg == '0) ? DONE : RD_SI;
      end
      RD_SI: begin
        s_addr     = ADDR_WIDTH'(i_reg);
        state_next = WAIT_SI;
      end
      WAIT_SI: state_next = RD_SJ;
      RD_SJ: begin
        s_addr     = ADDR_WIDTH'(j_reg);
        state_next = WAIT_SJ;
      end
      WAIT_SJ: state_next = WR_SI;
      WR_SI: begin
        s_addr     = ADDR_WIDTH'(i_reg);
        s_data     = sj_reg;
        s_wren     = 1'b1;
        state_next = WR_SJ;
      end
      WR_SJ: begin
        s_addr     = ADDR_WIDTH'(j_reg);
        s_data     = si_reg;
        s_wren     = 1'b1;
        state_next = RD_PAD;
      end
      RD_PAD: begin
        s_addr     = ADDR_WIDTH'(pad_idx);
        msg_addr   = ADDR_WIDTH'(k_reg);
        state_next = WAIT_PAD;
      end
      WAIT_PAD: state_next = bad_byte ? DONE : WR_OUT;
      WR_OUT: begin
        result_addr = ADDR_WIDTH'(k_reg);
        result_data = out_reg;
        result_wren = 1'b1;
        state_next  = (k_reg == len_reg) ? DONE : RD_SI;
      end
      DONE: begin
        rdy    = 1'b1;
        finish = 1'b1;
        if (start) state_next = RD_LEN;
      end
      default: state_next = IDLE;
    endcase
  end

  // i and k advance together on every entry into RD_SI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_reg   <= '0;
      j_reg   <= '0;
      si_reg  <= '0;
      sj_reg  <= '0;
      out_reg <= '0;
      k_reg   <= '0;
      len_reg <= '0;
    end else if (accept) begin
      i_reg <= '0;
      j_reg <= '0;
      k_reg <= '0;
    end else begin
      case (state_reg)
        WAIT_LEN: len_reg <= (len_raw > LEN_MAX) ? LEN_MAX : len_raw;
        WR_LEN, WR_OUT: begin
          if (state_next == RD_SI) begin
            i_reg <= i_reg + 1'b1;
            k_reg <= k_reg + 1'b1;
          end
        end
        WAIT_SI: begin
          si_reg <= s_q;
          j_reg  <= j_reg + s_q;
        end
        WAIT_SJ:  sj_reg  <= s_q;
        WAIT_PAD: out_reg <= plain;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_prga_engine.sv
// Self-checking bench: ARC4 reference model, write scoreboard and directed runs.
module tb_arc4_prga_engine;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int LMAX = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rdy, finish, result_wren, s_wren, key_valid;
  logic [AW-1:0] msg_addr, result_addr, s_addr;
  logic [DW-1:0] msg_q, result_data, s_data, s_q;

  always #5 clk = ~clk;

  arc4_prga_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MSG_LEN_MAX(LMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rdy(rdy), .finish(finish),
    .msg_addr(msg_addr), .msg_q(msg_q),
    .result_addr(result_addr), .result_data(result_data), .result_wren(result_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .key_valid(key_valid)
  );

  logic [7:0] msg_mem [256];
  logic [7:0] s_mem   [256];
  logic [7:0] s_init  [256];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    msg_q <= msg_mem[msg_addr];
    s_q   <= s_mem[s_addr];
    if (load_req) begin
      for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_data;
    end
  end

  typedef struct { int addr; int data; } wr_t;
  wr_t res_q[$];
  wr_t sx_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int res_wr_total = 0;
  int s_wr_total   = 0;
  int mon_res0 = -1;

  int         exp_len, exp_res_n, exp_s_n, last_lat, last_res_writes;
  bit         exp_abort;
  logic [7:0] exp_s     [256];
  logic [7:0] exp_plain [256];

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Every write strobe must match the next write the model predicts.
  initial forever begin
    @(negedge clk);
    if (result_wren) begin
      wr_t e;
      res_wr_total++;
      if (result_addr == 0) mon_res0 = int'(result_data);
      if (res_q.size() == 0) chk("res_unexpected_write_addr", int'(result_addr), -1);
      else begin
        e = res_q.pop_front();
        chk("res_addr", int'(result_addr), e.addr);
        chk("res_data", int'(result_data), e.data);
      end
    end
    if (s_wren) begin
      wr_t e;
      s_wr_total++;
      if (sx_q.size() == 0) chk("s_unexpected_write_addr", int'(s_addr), -1);
      else begin
        e = sx_q.pop_front();
        chk("s_addr", int'(s_addr), e.addr);
        chk("s_data", int'(s_data), e.data);
      end
    end
  end

  // Reference: plain ARC4 PRGA over a copy of s_init.
  task automatic model_run();
    logic [7:0] S [256];
    logic [7:0] t, p;
    int i, j, L;
    for (int n = 0; n < 256; n++) S[n] = s_init[n];
    L = int'(msg_mem[0]);
    exp_len = (L > LMAX) ? LMAX : L;
    exp_abort = 1'b0;
    res_q.push_back('{0, exp_len});
    i = 0; j = 0;
    for (int k = 1; k <= exp_len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(S[i])) % 256;
      sx_q.push_back('{i, int'(S[j])});
      sx_q.push_back('{j, int'(S[i])});
      t = S[i]; S[i] = S[j]; S[j] = t;
      p = msg_mem[k] ^ S[(int'(S[i]) + int'(S[j])) % 256];
      exp_plain[k] = p;
`ifdef ARC4_ASCII_CHECK_EN
      if (p < 8'h20 || p > 8'h7E) begin
        exp_abort = 1'b1;
        break;
      end
`endif
      res_q.push_back('{k, int'(p)});
    end
    for (int n = 0; n < 256; n++) exp_s[n] = S[n];
    exp_res_n = res_q.size();
    exp_s_n   = sx_q.size();
  endtask

  // Ciphertext whose plaintext is "ABC..." under keystream from s_init.
  task automatic make_cipher(input int n);
    logic [7:0] S [256];
    logic [7:0] t;
    int i, j;
    for (int m = 0; m < 256; m++) S[m] = s_init[m];
    i = 0; j = 0;
    for (int k = 1; k <= n; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(S[i])) % 256;
      t = S[i]; S[i] = S[j]; S[j] = t;
      msg_mem[k] = S[(int'(S[i]) + int'(S[j])) % 256] ^ (8'h41 + 8'((k - 1) % 26));
    end
  endtask

  task automatic set_identity();
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
  endtask

  task automatic clear_msg();
    for (int n = 0; n < 256; n++) msg_mem[n] = 8'h00;
  endtask

  task automatic load_s();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input bit pulse_mid);
    int lat, r0, s0, mism;
    load_s();
    model_run();
    r0 = res_wr_total;
    s0 = s_wr_total;
    @(negedge clk);
    chk({tag, "_rdy_before"}, rdy, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_finish_drop"}, finish, 0);
    chk({tag, "_rdy_busy"}, rdy, 0);
    chk({tag, "_key_valid_start"}, key_valid, 1);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (pulse_mid) start = (lat >= 5 && lat <= 8);
      if (finish) break;
      if (lat > 2000) begin
        chk({tag, "_timeout_cycles"}, lat, -1);
        break;
      end
    end
    start = 1'b0;
    last_lat = lat;
    if (!exp_abort) chk({tag, "_latency"}, lat, 3 + 9 * exp_len);
    chk({tag, "_key_valid"}, key_valid, exp_abort ? 0 : 1);
    @(negedge clk);
    chk({tag, "_finish_held"}, finish, 1);
    chk({tag, "_rdy_done"}, rdy, 1);
    last_res_writes = res_wr_total - r0;
    chk({tag, "_res_writes"}, last_res_writes, exp_res_n);
    chk({tag, "_s_writes"}, s_wr_total - s0, exp_s_n);
    mism = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) mism++;
    chk({tag, "_final_S_mismatches"}, mism, 0);
    $display("run %s: len=%0d latency=%0d result_writes=%0d key_valid=%0d",
             tag, exp_len, lat, last_res_writes, key_valid);
  endtask

  initial begin
    set_identity();
    clear_msg();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", rdy, 1);
    chk("reset_finish", finish, 0);
    chk("reset_wren", {30'd0, result_wren, s_wren}, 0);
    chk("reset_addrs", int'({msg_addr, result_addr, s_addr}), 0);
    chk("reset_data", int'({result_data, s_data}), 0);
    chk("reset_key_valid", key_valid, 1);
    @(negedge clk) rst_n = 1'b1;

    // Single byte, identity S: swap at i==j leaves S intact.
    set_identity(); clear_msg();
    msg_mem[0] = 8'h01; msg_mem[1] = 8'h41;
    run_and_check("t1_one_byte", 1'b0);
    chk("t1_plain_literal", int'(exp_plain[1]), 8'h43);
    chk("t1_latency_literal", last_lat, 12);
    chk("t1_S1_literal", int'(s_mem[1]), 1);
    chk("t1_S2_literal", int'(s_mem[2]), 2);

    // Zero length.
    clear_msg();
    run_and_check("t2_zero_len", 1'b0);
    chk("t2_latency_literal", last_lat, 3);
    chk("t2_res0_literal", mon_res0, 0);

    // Non-printable first byte.
    set_identity(); clear_msg();
    msg_mem[0] = 8'h02; msg_mem[1] = 8'h02; msg_mem[2] = 8'h41;
    run_and_check("t3_ascii", 1'b0);
    chk("t3_plain1_literal", int'(exp_plain[1]), 8'h00);
`ifdef ARC4_ASCII_CHECK_EN
    chk("t3_res_writes_literal", last_res_writes, 1);
    chk("t3_key_valid_literal", key_valid, 0);
`else
    chk("t3_res_writes_literal", last_res_writes, 3);
    chk("t3_key_valid_literal", key_valid, 1);
`endif

    // Length clamp with a scrambled S.
    set_identity();
    for (int n = 0; n < 64; n++) begin
      int a, b;
      logic [7:0] t;
      a = $urandom_range(255); b = $urandom_range(255);
      t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
    end
    clear_msg();
    make_cipher(200);
    msg_mem[0] = 8'hC8;
    run_and_check("t4_clamp", 1'b0);
    chk("t4_res0_literal", mon_res0, 8'h20);
    chk("t4_res_writes_literal", last_res_writes, 33);

    // Reset in the middle of a run, then a clean rerun.
    set_identity(); clear_msg();
    make_cipher(10);
    msg_mem[0] = 8'h0A;
    load_s();
    model_run();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy", rdy, 1);
    chk("t5_rst_finish", finish, 0);
    chk("t5_rst_wren", {30'd0, result_wren, s_wren}, 0);
    chk("t5_rst_addrs", int'({msg_addr, result_addr, s_addr}), 0);
    chk("t5_rst_key_valid", key_valid, 1);
    @(negedge clk) rst_n = 1'b1;
    res_q.delete();
    sx_q.delete();
    clear_msg();
    make_cipher(5);
    msg_mem[0] = 8'h05;
    run_and_check("t5_after_reset", 1'b0);

    // 32-byte vector with start pulsed while busy.
    set_identity(); clear_msg();
    make_cipher(32);
    msg_mem[0] = 8'h20;
    chk("t6_msg1_literal", int'(msg_mem[1]), 8'h43);
    chk("t6_msg2_literal", int'(msg_mem[2]), 8'h47);
    chk("t6_msg3_literal", int'(msg_mem[3]), 8'h44);
    chk("t6_msg4_literal", int'(msg_mem[4]), 8'h49);
    run_and_check("t6_start_ignored", 1'b1);
    chk("t6_latency_literal", last_lat, 3 + 9 * 32);
    chk("t6_plain32_literal", int'(exp_plain[32]), 8'h46);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
